// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the hub-wheel drive sequencer.
//   seq_state_t      : sequencer FSM states
//   MAG_W            : width of the drive magnitude handed to brushless
//   HALL_BAD_LO/HI   : hall codes that a healthy sensor set never produces
package mtr_drv_pkg;

  localparam int MAG_W = 12;

  localparam logic [2:0] HALL_BAD_LO = 3'b000;
  localparam logic [2:0] HALL_BAD_HI = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_RUN,
    ST_BRAKE,
    ST_FAULT
  } seq_state_t;

endpackage

// File: rtl/hall_mon.sv
// Hall sensor monitor: synchronizes the three raw hall lines and flags
// any change in the code and any illegal code.
//   clk, rst                   : system clock, synchronous active-high reset
//   hallGrn, hallYlw, hallBlu  : raw asynchronous hall inputs
//   hall_chg                   : registered, high for one cycle per code change
//   hall_bad                   : registered, high while the synced code is illegal
module hall_mon
  import mtr_drv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hallGrn,
  input  logic hallYlw,
  input  logic hallBlu,
  output logic hall_chg,
  output logic hall_bad
);

  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;

  // Two flops of synchronization, a third copy for change detection, and
  // registered flags, so a pin change is visible to the sequencer three
  // cycles after it happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 3'b000;
      sync2    <= 3'b000;
      prev     <= 3'b000;
      hall_chg <= 1'b0;
      hall_bad <= 1'b0;
    end else begin
      sync1    <= {hallGrn, hallYlw, hallBlu};
      sync2    <= sync1;
      prev     <= sync2;
      hall_chg <= (sync2 != prev);
      hall_bad <= (sync2 == HALL_BAD_LO) || (sync2 == HALL_BAD_HI);
    end
  end

endmodule

// File: rtl/mtr_drv_seq.sv
// Drive sequencer upstream of brushless: soft-ramps drv_mag toward the
// requested magnitude, handles braking, and latches a fault on stalled or
// illegal hall sequences.
//   clk, rst         : system clock, synchronous active-high reset
//   en               : run request (0 ramps the drive down to zero)
//   target_mag       : requested drive magnitude
//   brake_req        : level brake request
//   clr_fault        : fault clear pulse, honoured only with en=0
//   hallGrn/Ylw/Blu  : raw hall lines shared with brushless
//   drv_mag          : registered magnitude to brushless
//   brake_n          : registered active-low brake to brushless
//   at_speed         : high only in RUN
//   fault            : high only in FAULT
module mtr_drv_seq
  import mtr_drv_pkg::*;
#(
  parameter int unsigned RAMP_DIV     = 2048,
  parameter int unsigned STEP         = 16,
  parameter int unsigned STALL_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [MAG_W-1:0] target_mag,
  input  logic             brake_req,
  input  logic             clr_fault,
  input  logic             hallGrn,
  input  logic             hallYlw,
  input  logic             hallBlu,
  output logic [MAG_W-1:0] drv_mag,
  output logic             brake_n,
  output logic             at_speed,
  output logic             fault
);

  localparam int TICK_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(RAMP_DIV - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [MAG_W:0]     STEP_X     = (MAG_W + 1)'(STEP);

  seq_state_t state;
  seq_state_t state_nxt;

  logic [TICK_W-1:0]  tick_cnt;
  logic [TICK_W-1:0]  tick_cnt_nxt;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_cnt_nxt;

  logic [MAG_W-1:0] eff_target;
  logic [MAG_W-1:0] ramp_mag;
  logic [MAG_W-1:0] drv_mag_nxt;
  logic [MAG_W:0]   mag_x;
  logic [MAG_W:0]   tgt_x;
  logic [MAG_W:0]   up_x;
  logic [MAG_W:0]   dn_x;

  logic hall_chg;
  logic hall_bad;
  logic tick;
  logic stall;
  logic drive_st;

  hall_mon u_hall_mon (
    .clk      (clk),
    .rst      (rst),
    .hallGrn  (hallGrn),
    .hallYlw  (hallYlw),
    .hallBlu  (hallBlu),
    .hall_chg (hall_chg),
    .hall_bad (hall_bad)
  );

  assign eff_target = en ? target_mag : '0;
  assign drive_st   = (state == ST_RAMP) || (state == ST_RUN);
  assign tick       = (state == ST_RAMP) && (tick_cnt == TICK_LAST);
  assign stall      = (stall_cnt == STALL_LAST);

  // One ramp step toward the effective target. The arithmetic is one bit
  // wider than drv_mag so the distance check never wraps, and a step that
  // would reach or pass the target lands exactly on it.
  always_comb begin
    mag_x    = {1'b0, drv_mag};
    tgt_x    = {1'b0, eff_target};
    up_x     = mag_x + STEP_X;
    dn_x     = mag_x - STEP_X;
    ramp_mag = drv_mag;
    if (tgt_x > mag_x) begin
      if ((tgt_x - mag_x) <= STEP_X) begin
        ramp_mag = eff_target;
      end else begin
        ramp_mag = up_x[MAG_W-1:0];
      end
    end else if (tgt_x < mag_x) begin
      if ((mag_x - tgt_x) <= STEP_X) begin
        ramp_mag = eff_target;
      end else begin
        ramp_mag = dn_x[MAG_W-1:0];
      end
    end
  end

  // Next-state decision. A latched fault outranks everything; a stall or
  // illegal hall code while driving outranks a brake request, so the two
  // arriving together still end in FAULT.
  always_comb begin
    state_nxt = state;
    if (state == ST_FAULT) begin
      if (clr_fault && !en) begin
        state_nxt = ST_IDLE;
      end
    end else if (drive_st && (stall || hall_bad)) begin
      state_nxt = ST_FAULT;
    end else if (brake_req) begin
      state_nxt = ST_BRAKE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && (target_mag != '0)) begin
            state_nxt = ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (en && (drv_mag == eff_target)) begin
            state_nxt = ST_RUN;
          end else if (!en && (drv_mag == '0)) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!en || (target_mag != drv_mag)) begin
            state_nxt = ST_RAMP;
          end
        end
        ST_BRAKE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Ramp tick counter only advances while staying in RAMP, so it restarts
  // from zero on every RAMP entry but survives a target change mid-ramp.
  // The stall counter saturates so a fault cannot be missed by wrapping.
  always_comb begin
    tick_cnt_nxt = '0;
    if ((state == ST_RAMP) && (state_nxt == ST_RAMP)) begin
      tick_cnt_nxt = tick ? '0 : tick_cnt + 1'b1;
    end

    stall_cnt_nxt = '0;
    if (drive_st && (drv_mag != '0) && !hall_chg) begin
      stall_cnt_nxt = stall ? stall_cnt : stall_cnt + 1'b1;
    end

    drv_mag_nxt = '0;
    if ((state_nxt == ST_RAMP) || (state_nxt == ST_RUN)) begin
      drv_mag_nxt = tick ? ramp_mag : drv_mag;
    end
  end

  // All outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      stall_cnt <= '0;
      drv_mag   <= '0;
      brake_n   <= 1'b1;
      at_speed  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      stall_cnt <= stall_cnt_nxt;
      drv_mag   <= drv_mag_nxt;
      brake_n   <= (state_nxt != ST_BRAKE);
      at_speed  <= (state_nxt == ST_RUN);
      fault     <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_mtr_drv_seq.sv
// Scoreboard bench for mtr_drv_seq. Stimulus pushes expected output
// vectors tagged with the clock edge they belong to; a negedge monitor
// pops and compares them. Halls rotate through the legal six-step code
// while "spinning", standing in for the motor model.
module tb_mtr_drv_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] target_mag;
  logic        brake_req;
  logic        clr_fault;
  logic [2:0]  hall_code;
  logic [11:0] drv_mag;
  logic        brake_n;
  logic        at_speed;
  logic        fault;

  typedef struct {
    int          at;
    string       name;
    logic [11:0] mag;
    logic        bn;
    logic        spd;
    logic        flt;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          checks;
  int          errors;
  logic        spin;
  int          spin_cnt;
  int          hall_idx;
  logic [2:0]  hall_seq [6];

  mtr_drv_seq #(
    .RAMP_DIV     (4),
    .STEP         (16),
    .STALL_CYCLES (1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .target_mag (target_mag),
    .brake_req  (brake_req),
    .clr_fault  (clr_fault),
    .hallGrn    (hall_code[2]),
    .hallYlw    (hall_code[1]),
    .hallBlu    (hall_code[0]),
    .drv_mag    (drv_mag),
    .brake_n    (brake_n),
    .at_speed   (at_speed),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge N, cyc reads N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic r, input logic e, input logic [11:0] t,
                               input logic b, input logic c);
    rst        = r;
    en         = e;
    target_mag = t;
    brake_req  = b;
    clr_fault  = c;
  endtask

  task automatic setHalls(input logic [2:0] code, input logic s);
    hall_code = code;
    spin      = s;
    spin_cnt  = 0;
  endtask

  // Advance n edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (spin) begin
        spin_cnt++;
        if (spin_cnt >= 40) begin
          spin_cnt  = 0;
          hall_idx  = (hall_idx + 1) % 6;
          hall_code = hall_seq[hall_idx];
        end
      end
    end
  endtask

  // Expect the given outputs just after the edge dly edges from now.
  task automatic expectAt(input int dly, input string nm, input logic [11:0] m,
                          input logic b, input logic s, input logic f);
    exp_t e;
    e.at   = cyc + dly;
    e.name = nm;
    e.mag  = m;
    e.bn   = b;
    e.spd  = s;
    e.flt  = f;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (e.at != cyc) begin
      errors++;
      $display("[TB] FAIL %s: compared at edge %0d, required edge %0d", e.name, cyc, e.at);
    end else if (drv_mag !== e.mag || brake_n !== e.bn || at_speed !== e.spd || fault !== e.flt) begin
      errors++;
      $display("[TB] FAIL %s @edge %0d: got mag=%h brake_n=%b at_speed=%b fault=%b, required mag=%h brake_n=%b at_speed=%b fault=%b",
               e.name, cyc, drv_mag, brake_n, at_speed, fault, e.mag, e.bn, e.spd, e.flt);
    end
  endtask

  // Monitor: compares every expectation due at this edge.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    hall_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    hall_idx = 5;
    setHalls(3'b101, 1'b0);
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);

    // Reset state
    step(1);
    expectAt(1, "reset", 12'h000, 1'b1, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    expectAt(1, "idle_after_reset", 12'h000, 1'b1, 1'b0, 1'b0);
    step(6);

    // Ramp up to 0x7FF with halls turning
    $display("[TB] ramp up");
    setHalls(3'b101, 1'b1);
    applyStimulus(1'b0, 1'b1, 12'h7FF, 1'b0, 1'b0);
    expectAt(1,   "ramp_enter",   12'h000, 1'b1, 1'b0, 1'b0);
    expectAt(4,   "pre_tick1",    12'h000, 1'b1, 1'b0, 1'b0);
    expectAt(5,   "tick1",        12'h010, 1'b1, 1'b0, 1'b0);
    expectAt(9,   "tick2",        12'h020, 1'b1, 1'b0, 1'b0);
    expectAt(509, "tick127",      12'h7F0, 1'b1, 1'b0, 1'b0);
    expectAt(512, "hold127",      12'h7F0, 1'b1, 1'b0, 1'b0);
    expectAt(513, "tick128_sat",  12'h7FF, 1'b1, 1'b0, 1'b0);
    expectAt(514, "run_entry",    12'h7FF, 1'b1, 1'b1, 1'b0);
    expectAt(700, "run_hold",     12'h7FF, 1'b1, 1'b1, 1'b0);
    step(700);

    // Ramp down from RUN at 0x7FF
    $display("[TB] ramp down");
    applyStimulus(1'b0, 1'b0, 12'h7FF, 1'b0, 1'b0);
    expectAt(1,   "down_enter",   12'h7FF, 1'b1, 1'b0, 1'b0);
    expectAt(5,   "down_tick1",   12'h7EF, 1'b1, 1'b0, 1'b0);
    expectAt(509, "down_tick127", 12'h00F, 1'b1, 1'b0, 1'b0);
    expectAt(513, "down_tick128", 12'h000, 1'b1, 1'b0, 1'b0);
    expectAt(514, "down_idle",    12'h000, 1'b1, 1'b0, 1'b0);
    step(520);

    // Brake mid-ramp at 0x200, release, re-ramp, then reset at 0x300
    $display("[TB] brake mid-ramp");
    applyStimulus(1'b0, 1'b1, 12'h7FF, 1'b0, 1'b0);
    expectAt(129, "at_0x200", 12'h200, 1'b1, 1'b0, 1'b0);
    step(129);
    applyStimulus(1'b0, 1'b1, 12'h7FF, 1'b1, 1'b0);
    expectAt(1, "brake_entry", 12'h000, 1'b0, 1'b0, 1'b0);
    expectAt(3, "brake_hold",  12'h000, 1'b0, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b1, 12'h7FF, 1'b0, 1'b0);
    expectAt(1,   "brake_release", 12'h000, 1'b1, 1'b0, 1'b0);
    expectAt(5,   "reramp_pre",    12'h000, 1'b1, 1'b0, 1'b0);
    expectAt(6,   "reramp_tick1",  12'h010, 1'b1, 1'b0, 1'b0);
    expectAt(194, "at_0x300",      12'h300, 1'b1, 1'b0, 1'b0);
    step(194);
    $display("[TB] reset mid-ramp");
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    expectAt(1, "rst_midramp",  12'h000, 1'b1, 1'b0, 1'b0);
    expectAt(2, "rst_hold",     12'h000, 1'b1, 1'b0, 1'b0);
    step(2);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(6);

    // Stall: halls frozen at 101; brake arrives in the same cycle as stall
    $display("[TB] stall");
    setHalls(3'b101, 1'b0);
    applyStimulus(1'b0, 1'b1, 12'h100, 1'b0, 1'b0);
    expectAt(66,   "stall_run",      12'h100, 1'b1, 1'b1, 1'b0);
    expectAt(1004, "stall_edge_pre", 12'h100, 1'b1, 1'b1, 1'b0);
    expectAt(1005, "stall_fault",    12'h000, 1'b1, 1'b0, 1'b1);
    step(1004);
    applyStimulus(1'b0, 1'b1, 12'h100, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b1, 12'h100, 1'b1, 1'b1);
    expectAt(1, "clr_with_en", 12'h000, 1'b1, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b1, 12'h100, 1'b0, 1'b0);
    expectAt(2, "fault_hold", 12'h000, 1'b1, 1'b0, 1'b1);
    step(2);
    applyStimulus(1'b0, 1'b0, 12'h100, 1'b0, 1'b1);
    expectAt(1, "fault_clear", 12'h000, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    setHalls(3'b101, 1'b1);
    step(6);

    // Illegal hall code during RUN
    $display("[TB] illegal hall");
    applyStimulus(1'b0, 1'b1, 12'h040, 1'b0, 1'b0);
    expectAt(30, "small_run", 12'h040, 1'b1, 1'b1, 1'b0);
    step(30);
    setHalls(3'b000, 1'b0);
    expectAt(3, "illegal_pre",   12'h040, 1'b1, 1'b1, 1'b0);
    expectAt(4, "illegal_fault", 12'h000, 1'b1, 1'b0, 1'b1);
    expectAt(8, "illegal_hold",  12'h000, 1'b1, 1'b0, 1'b1);
    step(8);
    setHalls(3'b101, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'h040, 1'b0, 1'b1);
    expectAt(1, "illegal_clear", 12'h000, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(4);

    if (sb.size() != 0) begin
      $display("[TB] FAIL pending: %0d expectations never compared, required 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
